// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream handshake (tvalid/tready/tdata) between a producer and a consumer.
//   master: drives tvalid/tdata, receives tready
//   slave : receives tvalid/tdata, drives tready
interface uart_rx_if;
  import uart_pkg::*;

  logic                      tvalid;
  logic                      tready;
  logic [UART_DATA_BITS-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to 1
// so an idle-high line does not look like an edge coming out of reset.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized output (2-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output.
//   clk, rst_n      : clock, async active-low reset
//   rx              : asynchronous serial input, idle high
//   framing_error   : one-cycle pulse when a stop bit is sampled low
//   overrun         : one-cycle pulse when a byte completes while the output is still full
//   stream (master) : tvalid/tready/tdata received-byte output
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned cycles_per_bit = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic framing_error,
  output logic overrun,
  uart_rx_if.master stream
);

  localparam int unsigned CNT_W = $clog2(cycles_per_bit);
  localparam int unsigned HALF  = cycles_per_bit / 2;
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(cycles_per_bit - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [IDX_W-1:0]          bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic                      deliver_c;
  logic                      frame_err_c;
  logic                      valid_r;
  logic [UART_DATA_BITS-1:0] data_r;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // FSM and datapath state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
    end
  end

  // Next-state: the counter runs freely in START/DATA/STOP and restarts at each sample point
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 1'b1;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    deliver_c    = 1'b0;
    frame_err_c  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) state_next = RX_STOP;
          else                     bit_idx_next = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            deliver_c  = 1'b1;
            state_next = RX_IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_next  = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_next = '0;
        if (rx_s) state_next = RX_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = RX_IDLE;
      end
    endcase
  end

  // Output register: a completed byte is dropped (overrun) only if the held byte is not leaving this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r       <= 1'b0;
      data_r        <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_err_c;
      overrun       <= 1'b0;
      if (deliver_c && (!valid_r || stream.tready)) begin
        data_r  <= shreg;
        valid_r <= 1'b1;
      end else begin
        if (deliver_c)                overrun <= 1'b1;
        if (valid_r && stream.tready) valid_r <= 1'b0;
      end
    end
  end

  assign stream.tvalid = valid_r;
  assign stream.tdata  = data_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// and a 434-cycles-per-bit loopback instance fed by a behavioural transmitter.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB    = 16;
  localparam int unsigned CPB_LB = 434;
  localparam int unsigned HALF   = CPB / 2;
  // Pin-to-t0 delay: two synchronizer flops, then the edge on which IDLE sees the low level.
  localparam int unsigned LAT    = 3;
  localparam int unsigned TCLK   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic rx_lb = 1'b1;
  logic fe, ovr, fe_lb, ovr_lb;

  uart_rx_if bus ();
  uart_rx_if bus_lb ();

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .framing_error (fe),
    .overrun       (ovr),
    .stream        (bus)
  );

  uart_rx #(.cycles_per_bit(CPB_LB)) dut_lb (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx_lb),
    .framing_error (fe_lb),
    .overrun       (ovr_lb),
    .stream        (bus_lb)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observation: transfers, pulses and tvalid activity, sampled 1ns after each falling edge
  logic [7:0] got_q[$];
  logic [7:0] got_lb[$];
  int  fe_cnt, ovr_cnt, tv_cycles, fe_lb_cnt, ovr_lb_cnt;
  time rise_t;
  logic tv_prev = 1'b0;

  always @(negedge clk) begin
    #1;
    if (bus.tvalid && bus.tready)       got_q.push_back(bus.tdata);
    if (bus_lb.tvalid && bus_lb.tready) got_lb.push_back(bus_lb.tdata);
    if (fe)     fe_cnt++;
    if (ovr)    ovr_cnt++;
    if (fe_lb)  fe_lb_cnt++;
    if (ovr_lb) ovr_lb_cnt++;
    if (bus.tvalid) tv_cycles++;
    if (bus.tvalid && !tv_prev) rise_t = $time;
    tv_prev = bus.tvalid;
  end

  task automatic clear_obs();
    got_q.delete();
    got_lb.delete();
    fe_cnt = 0; ovr_cnt = 0; tv_cycles = 0; fe_lb_cnt = 0; ovr_lb_cnt = 0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 10-bit frame LSB first; the line is left at the stop-bit level
  task automatic send(input logic [7:0] b, input logic stop, input int unsigned cpb,
                      input bit lb, output time t_start);
    logic [9:0] frame;
    frame   = {stop, b, 1'b0};
    t_start = $time;
    for (int i = 0; i < 10; i++) begin
      if (lb) rx_lb = frame[i];
      else    rx    = frame[i];
      idle(cpb);
    end
  endtask

  task automatic expect_one(input string tag, input logic [7:0] exp);
    check({tag, "_count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    logic [7:0] lb_bytes[3];

    bus.tready    = 1'b1;
    bus_lb.tready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    check("rst_tvalid", 32'(bus.tvalid), 32'd0);
    check("rst_tdata",  32'(bus.tdata),  32'd0);
    check("rst_ferr",   32'(fe),         32'd0);
    check("rst_ovr",    32'(ovr),        32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single frame: one-cycle tvalid at the mid-stop-bit timing
    clear_obs();
    send(8'h5A, 1'b1, CPB, 1'b0, t);
    idle(4);
    expect_one("f5a", 8'h5A);
    check("f5a_rise_time", 32'(rise_t - t), 32'((LAT + HALF + 9 * CPB) * TCLK + 1));
    check("f5a_tvalid_cycles", 32'(tv_cycles), 32'd1);
    check("f5a_ferr", 32'(fe_cnt),  32'd0);
    check("f5a_ovr",  32'(ovr_cnt), 32'd0);

    // Short low glitch: no byte, no error; then a good frame
    clear_obs();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    check("glitch_bytes", 32'(got_q.size()), 32'd0);
    check("glitch_ferr",  32'(fe_cnt),       32'd0);
    check("glitch_tvalid_cycles", 32'(tv_cycles), 32'd0);
    send(8'h3C, 1'b1, CPB, 1'b0, t);
    idle(4);
    expect_one("f3c", 8'h3C);

    // Bad stop bit, line held low, then recovery
    clear_obs();
    b = 8'($urandom);
    send(b, 1'b0, CPB, 1'b0, t);
    idle(3 * CPB);
    rx = 1'b1;
    idle(CPB);
    send(8'hA5, 1'b1, CPB, 1'b0, t);
    idle(4);
    check("break_ferr_pulses", 32'(fe_cnt), 32'd1);
    expect_one("fa5", 8'hA5);
    check("break_ovr", 32'(ovr_cnt), 32'd0);

    // Output held full: second byte overruns, first byte survives
    clear_obs();
    bus.tready = 1'b0;
    send(8'h11, 1'b1, CPB, 1'b0, t);
    send(8'h22, 1'b1, CPB, 1'b0, t);
    idle(4);
    check("ovr_tvalid", 32'(bus.tvalid), 32'd1);
    check("ovr_tdata",  32'(bus.tdata),  32'h11);
    check("ovr_pulses", 32'(ovr_cnt),    32'd1);
    check("ovr_no_xfer", 32'(got_q.size()), 32'd0);
    bus.tready = 1'b1;
    idle(2);
    expect_one("ovr_drain", 8'h11);
    check("ovr_tvalid_after", 32'(bus.tvalid), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF
    clear_obs();
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(4 * CPB + CPB / 2);
    rst_n = 1'b0;
    idle(2);
    check("midrst_tvalid", 32'(bus.tvalid), 32'd0);
    check("midrst_tdata",  32'(bus.tdata),  32'd0);
    check("midrst_ferr",   32'(fe),         32'd0);
    check("midrst_ovr",    32'(ovr),        32'd0);
    rst_n = 1'b1;
    idle(CPB / 2 + 4 * CPB);
    check("midrst_no_byte", 32'(got_q.size()), 32'd0);
    check("midrst_no_ferr", 32'(fe_cnt),       32'd0);
    send(8'hC3, 1'b1, CPB, 1'b0, t);
    idle(4);
    expect_one("fc3", 8'hC3);

    // Random bytes with random idle gaps, including back-to-back frames
    clear_obs();
    for (int n = 0; n < 12; n++) begin
      int unsigned gap;
      b   = 8'($urandom);
      gap = $urandom_range(0, 3) * (CPB / 2);
      send(b, 1'b1, CPB, 1'b0, t);
      exp_q.push_back(b);
      if (gap != 0) idle(gap);
    end
    idle(4);
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int n = 0; n < 12; n++) begin
      if (got_q.size() > 0 && exp_q.size() > 0)
        check($sformatf("rand_byte%0d", n), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    check("rand_ferr", 32'(fe_cnt),  32'd0);
    check("rand_ovr",  32'(ovr_cnt), 32'd0);

    // Loopback at 434 cycles per bit, back-to-back
    clear_obs();
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'h55;
    for (int n = 0; n < 3; n++) send(lb_bytes[n], 1'b1, CPB_LB, 1'b1, t);
    idle(4);
    check("lb_count", 32'(got_lb.size()), 32'd3);
    for (int n = 0; n < 3; n++) begin
      if (got_lb.size() > 0)
        check($sformatf("lb_byte%0d", n), 32'(got_lb.pop_front()), 32'(lb_bytes[n]));
    end
    check("lb_ferr", 32'(fe_lb_cnt),  32'd0);
    check("lb_ovr",  32'(ovr_lb_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
